// File: rtl/pipe_stage_regs.sv
// pipe_stage_regs
// ---------------
// Pipeline register bank for a five-stage Y86-64 core. It holds three groups
// of registers and a set of performance counters:
//   - F: the predicted PC.
//   - D: the fetch-to-decode register.
//   - E: the decode-to-execute register.
//   - Saturating counters for cycles, inserted bubbles and stall cycles.
// The hazard unit's stall and bubble requests act on these registers.
// A halt from writeback freezes every register and every counter.
//
// Ports
//   clk, rst                  rising-edge clock, synchronous active-high reset
//   F_stall                   hold the F register
//   D_stall, D_bubble         hold or flush the D register (stall wins)
//   E_bubble                  flush the E register
//   halt                      freeze every register and counter
//   f_predPC -> F_predPC      predicted PC
//   f_* -> D_*                fetch outputs into the decode register
//   d_* -> E_*                decode outputs into the execute register
//   cyc_cnt                   non-halted cycles since reset
//   bubble_cnt                bubbles inserted into D plus bubbles inserted into E
//   stall_cnt                 cycles with D_stall applied
module pipe_stage_regs #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             F_stall,
  input  logic             D_stall,
  input  logic             D_bubble,
  input  logic             E_bubble,
  input  logic             halt,
  input  logic [63:0]      f_predPC,
  output logic [63:0]      F_predPC,
  input  logic [3:0]       f_stat,
  input  logic [3:0]       f_icode,
  input  logic [3:0]       f_ifun,
  input  logic [3:0]       f_rA,
  input  logic [3:0]       f_rB,
  input  logic [63:0]      f_valC,
  input  logic [63:0]      f_valP,
  output logic [3:0]       D_stat,
  output logic [3:0]       D_icode,
  output logic [3:0]       D_ifun,
  output logic [3:0]       D_rA,
  output logic [3:0]       D_rB,
  output logic [63:0]      D_valC,
  output logic [63:0]      D_valP,
  input  logic [3:0]       d_stat,
  input  logic [3:0]       d_icode,
  input  logic [3:0]       d_ifun,
  input  logic [63:0]      d_valC,
  input  logic [63:0]      d_valA,
  input  logic [63:0]      d_valB,
  input  logic [3:0]       d_dstE,
  input  logic [3:0]       d_dstM,
  input  logic [3:0]       d_srcA,
  input  logic [3:0]       d_srcB,
  output logic [3:0]       E_stat,
  output logic [3:0]       E_icode,
  output logic [3:0]       E_ifun,
  output logic [63:0]      E_valC,
  output logic [63:0]      E_valA,
  output logic [63:0]      E_valB,
  output logic [3:0]       E_dstE,
  output logic [3:0]       E_dstM,
  output logic [3:0]       E_srcA,
  output logic [3:0]       E_srcB,
  output logic [CNT_W-1:0] cyc_cnt,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [3:0] STAT_AOK  = 4'h1;
  localparam logic [3:0] ICODE_NOP = 4'h1;
  localparam logic [3:0] RNONE     = 4'hF;

  typedef struct packed {
    logic [3:0]  stat;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [63:0] valc;
    logic [63:0] valp;
  } d_reg_t;

  typedef struct packed {
    logic [3:0]  stat;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [63:0] valc;
    logic [63:0] vala;
    logic [63:0] valb;
    logic [3:0]  dste;
    logic [3:0]  dstm;
    logic [3:0]  srca;
    logic [3:0]  srcb;
  } e_reg_t;

  // A bubble is a NOP that carries an AOK status. It touches no register,
  // so every register field is RNONE.
  localparam d_reg_t D_BUBBLE = '{stat: STAT_AOK, icode: ICODE_NOP, ifun: 4'h0,
                                  ra: RNONE, rb: RNONE, valc: 64'h0, valp: 64'h0};
  localparam e_reg_t E_BUBBLE = '{stat: STAT_AOK, icode: ICODE_NOP, ifun: 4'h0,
                                  valc: 64'h0, vala: 64'h0, valb: 64'h0,
                                  dste: RNONE, dstm: RNONE, srca: RNONE, srcb: RNONE};

  logic [63:0]      f_pc_q, f_pc_d;
  d_reg_t           d_q, d_d;
  e_reg_t           e_q, e_d;
  logic [CNT_W-1:0] cyc_cnt_q, cyc_cnt_d;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic             d_bubble_fire;
  logic             e_bubble_fire;
  logic [1:0]       bubble_inc;
  logic [CNT_W:0]   cyc_sum;
  logic [CNT_W:0]   bubble_sum;
  logic [CNT_W:0]   stall_sum;

  // Next-state logic for the pipeline registers.
  // Halt has top priority and holds everything. On D, a stall beats a bubble.
  always_comb begin
    f_pc_d = f_pc_q;
    d_d    = d_q;
    e_d    = e_q;
    if (!halt) begin
      if (!F_stall) begin
        f_pc_d = f_predPC;
      end
      if (!D_stall) begin
        if (D_bubble) begin
          d_d = D_BUBBLE;
        end else begin
          d_d = '{stat: f_stat, icode: f_icode, ifun: f_ifun, ra: f_rA, rb: f_rB,
                  valc: f_valC, valp: f_valP};
        end
      end
      if (E_bubble) begin
        e_d = E_BUBBLE;
      end else begin
        e_d = '{stat: d_stat, icode: d_icode, ifun: d_ifun,
                valc: d_valC, vala: d_valA, valb: d_valB,
                dste: d_dstE, dstm: d_dstM, srca: d_srcA, srcb: d_srcB};
      end
    end
  end

  // Counter next-state logic.
  // Each sum is one bit wider than its counter, so the carry out of the top
  // bit flags an overflow. An overflowing sum clamps to all-ones; this also
  // covers a +2 step that starts at all-ones minus one.
  always_comb begin
    d_bubble_fire = !halt && !D_stall && D_bubble;
    e_bubble_fire = !halt && E_bubble;
    bubble_inc    = {1'b0, d_bubble_fire} + {1'b0, e_bubble_fire};
    cyc_sum       = {1'b0, cyc_cnt_q} + {{CNT_W{1'b0}}, 1'b1};
    bubble_sum    = {1'b0, bubble_cnt_q} + {{(CNT_W-1){1'b0}}, bubble_inc};
    stall_sum     = {1'b0, stall_cnt_q} + {{CNT_W{1'b0}}, D_stall};
    cyc_cnt_d     = cyc_cnt_q;
    bubble_cnt_d  = bubble_cnt_q;
    stall_cnt_d   = stall_cnt_q;
    if (!halt) begin
      cyc_cnt_d    = cyc_sum[CNT_W]    ? '1 : cyc_sum[CNT_W-1:0];
      bubble_cnt_d = bubble_sum[CNT_W] ? '1 : bubble_sum[CNT_W-1:0];
      stall_cnt_d  = stall_sum[CNT_W]  ? '1 : stall_sum[CNT_W-1:0];
    end
  end

  // Register update. Reset overrides halt, stall and bubble on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      f_pc_q       <= RESET_PC;
      d_q          <= D_BUBBLE;
      e_q          <= E_BUBBLE;
      cyc_cnt_q    <= '0;
      bubble_cnt_q <= '0;
      stall_cnt_q  <= '0;
    end else begin
      f_pc_q       <= f_pc_d;
      d_q          <= d_d;
      e_q          <= e_d;
      cyc_cnt_q    <= cyc_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign F_predPC   = f_pc_q;
  assign D_stat     = d_q.stat;
  assign D_icode    = d_q.icode;
  assign D_ifun     = d_q.ifun;
  assign D_rA       = d_q.ra;
  assign D_rB       = d_q.rb;
  assign D_valC     = d_q.valc;
  assign D_valP     = d_q.valp;
  assign E_stat     = e_q.stat;
  assign E_icode    = e_q.icode;
  assign E_ifun     = e_q.ifun;
  assign E_valC     = e_q.valc;
  assign E_valA     = e_q.vala;
  assign E_valB     = e_q.valb;
  assign E_dstE     = e_q.dste;
  assign E_dstM     = e_q.dstm;
  assign E_srcA     = e_q.srca;
  assign E_srcB     = e_q.srcb;
  assign cyc_cnt    = cyc_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
  assign stall_cnt  = stall_cnt_q;

endmodule
